// File: rtl/conv_sched_ctrl_pkg.sv
// conv_sched_ctrl_pkg
// Shared definitions for the convolution scheduler:
//   - default widths for the row/col, channel, output-channel, beat and
//     IFM slot counters
//   - controller state encoding
//   - helper telling whether the IFM row loader may run in a given state
package conv_sched_ctrl_pkg;

  localparam int DEF_W_SIZE       = 10;
  localparam int DEF_W_CHANNEL    = 8;
  localparam int DEF_W_OCH        = 8;
  localparam int DEF_W_FRAME_SIZE = 20;
  localparam int DEF_W_IFM_BUF    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILT  = 2'd1,
    ST_HSYNC = 2'd2,
    ST_DATA  = 2'd3
  } state_t;

  function automatic logic loader_state(input state_t s);
    return (s == ST_HSYNC) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/conv_sched_ctrl_ifm_row_prefetch.sv
// ifm_row_prefetch
// Ring-buffered IFM row loader. Tracks how many input rows have landed,
// issues one row request at a time, and reports when the window needed by
// the current output row is resident.
// Ports:
//   clk, rstn         clock, async active-low reset
//   active            loader enabled; low clears all loader state
//   r_in              input-aligned row of the current output row
//   height            frame height H
//   kernel3           1 = 3x3 window (half-width 1), 0 = 1x1
//   ifm_done          row load complete pulse
//   ifm_req           registered one-cycle row request
//   ifm_row, ifm_slot requested row and its ring slot
//   ready             window rows for r_in are all loaded
module ifm_row_prefetch #(
  parameter int W_SIZE      = 10,
  parameter int W_IFM_BUF   = 2,
  parameter int IFM_BUF_CNT = 1 << W_IFM_BUF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 active,
  input  logic [W_SIZE-1:0]    r_in,
  input  logic [W_SIZE-1:0]    height,
  input  logic                 kernel3,
  input  logic                 ifm_done,
  output logic                 ifm_req,
  output logic [W_SIZE-1:0]    ifm_row,
  output logic [W_IFM_BUF-1:0] ifm_slot,
  output logic                 ready
);

  // One extra bit so lo + IFM_BUF_CNT and hi + 1 cannot wrap.
  localparam int WE = W_SIZE + 1;

  logic [WE-1:0] rin_e, h_e, k_e, lo, hi, loaded;
  logic          busy, can_req;

  assign rin_e = WE'(r_in);
  assign h_e   = WE'(height);
  assign k_e   = WE'(kernel3);

  assign lo = (rin_e >= k_e) ? rin_e - k_e : '0;
  assign hi = (rin_e + k_e >= h_e) ? h_e - WE'(1) : rin_e + k_e;

  assign ready = loaded >= hi + WE'(1);

  // Capping loaded below lo + IFM_BUF_CNT keeps the next slot written
  // outside the live window [lo, hi].
  assign can_req = active && !busy && (loaded < h_e) &&
                   (loaded < lo + WE'(IFM_BUF_CNT));

  assign ifm_slot = ifm_row[W_IFM_BUF-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      loaded  <= '0;
      busy    <= 1'b0;
      ifm_req <= 1'b0;
      ifm_row <= '0;
    end else if (!active) begin
      loaded  <= '0;
      busy    <= 1'b0;
      ifm_req <= 1'b0;
    end else begin
      ifm_req <= can_req;
      if (can_req) begin
        busy    <= 1'b1;
        ifm_row <= loaded[W_SIZE-1:0];
      end else if (busy && ifm_done) begin
        busy   <= 1'b0;
        loaded <= loaded + WE'(1);
      end
    end
  end

endmodule

// File: rtl/conv_sched_ctrl.sv
// conv_sched_ctrl
// Convolution scheduler: walks col -> in-channel -> row -> out-channel tile,
// requesting a filter tile per output-channel tile and prefetching IFM rows
// through ifm_row_prefetch. Beats are issued only when the PE accepts them.
// Ports:
//   clk, rstn                 clock, async active-low reset
//   q_start                   start pulse (IDLE only), latches q_* config
//   q_width/q_height          input frame W, H
//   q_channel/q_och           input / output channel tile counts
//   q_kernel3/q_stride2       kernel and stride select
//   q_filt_done/q_ifm_done    buffer manager completions
//   q_pe_ready                PE accepts a beat
//   o_filt_req/o_filt_tile    filter tile request
//   o_ifm_req/o_ifm_row/slot  IFM row request and ring slot
//   o_data_valid              beat issued
//   o_row/o_col/o_chn/o_och   beat position (row/col input-aligned)
//   o_first/last_row/col      padding flags
//   o_beat_cnt                beats issued in current out-channel tile
//   o_done                    pulse after the final beat
//
// state  | meaning
// IDLE   | waiting for q_start
// FILT   | filter tile requested, waiting for q_filt_done
// HSYNC  | waiting for the current output row's IFM window
// DATA   | issuing beats for the current output row
module conv_sched_ctrl
  import conv_sched_ctrl_pkg::*;
#(
  parameter int W_SIZE       = DEF_W_SIZE,
  parameter int W_CHANNEL    = DEF_W_CHANNEL,
  parameter int W_OCH        = DEF_W_OCH,
  parameter int W_FRAME_SIZE = DEF_W_FRAME_SIZE,
  parameter int W_IFM_BUF    = DEF_W_IFM_BUF,
  parameter int IFM_BUF_CNT  = 1 << W_IFM_BUF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    q_start,
  input  logic [W_SIZE-1:0]       q_width,
  input  logic [W_SIZE-1:0]       q_height,
  input  logic [W_CHANNEL-1:0]    q_channel,
  input  logic [W_OCH-1:0]        q_och,
  input  logic                    q_kernel3,
  input  logic                    q_stride2,
  input  logic                    q_filt_done,
  input  logic                    q_ifm_done,
  input  logic                    q_pe_ready,
  output logic                    o_filt_req,
  output logic [W_OCH-1:0]        o_filt_tile,
  output logic                    o_ifm_req,
  output logic [W_SIZE-1:0]       o_ifm_row,
  output logic [W_IFM_BUF-1:0]    o_ifm_slot,
  output logic                    o_data_valid,
  output logic [W_SIZE-1:0]       o_row,
  output logic [W_SIZE-1:0]       o_col,
  output logic [W_CHANNEL-1:0]    o_chn,
  output logic [W_OCH-1:0]        o_och,
  output logic                    o_first_row,
  output logic                    o_last_row,
  output logic                    o_first_col,
  output logic                    o_last_col,
  output logic [W_FRAME_SIZE-1:0] o_beat_cnt,
  output logic                    o_done
);

  state_t state, state_nxt;

  logic [W_SIZE-1:0]       cfg_w, cfg_h, row, col, wo, ho, r_in, c_in;
  logic [W_CHANNEL-1:0]    cfg_c, chn;
  logic [W_OCH-1:0]        cfg_o, och;
  logic                    cfg_k3, cfg_s2;
  logic [W_FRAME_SIZE-1:0] beat_cnt;
  logic                    filt_req, done;
  logic                    beat, end_col, end_chn, end_row, end_och, row_wrap;
  logic                    in_data, loader_on, ifm_ready;

  // Output dimensions: ceil(dim / stride).
  assign wo = cfg_s2 ? (cfg_w >> 1) + W_SIZE'(cfg_w[0]) : cfg_w;
  assign ho = cfg_s2 ? (cfg_h >> 1) + W_SIZE'(cfg_h[0]) : cfg_h;

  assign r_in = cfg_s2 ? {row[W_SIZE-2:0], 1'b0} : row;
  assign c_in = cfg_s2 ? {col[W_SIZE-2:0], 1'b0} : col;

  assign beat     = (state == ST_DATA) && q_pe_ready;
  assign end_col  = col == wo - W_SIZE'(1);
  assign end_chn  = chn == cfg_c - W_CHANNEL'(1);
  assign end_row  = row == ho - W_SIZE'(1);
  assign end_och  = och == cfg_o - W_OCH'(1);
  assign row_wrap = beat && end_col && end_chn;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (q_start)     state_nxt = ST_FILT;
      ST_FILT:  if (q_filt_done) state_nxt = ST_HSYNC;
      ST_HSYNC: if (ifm_ready)   state_nxt = ST_DATA;
      ST_DATA: begin
        if (row_wrap) begin
          if (!end_row)      state_nxt = ST_HSYNC;
          else if (!end_och) state_nxt = ST_FILT;
          else               state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Loader follows the next state so that leaving for FILT clears it on the
  // same edge and entering HSYNC lets the first request go out immediately.
  assign loader_on = loader_state(state_nxt);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      filt_req <= 1'b0;
      done     <= 1'b0;
      cfg_w    <= '0;
      cfg_h    <= '0;
      cfg_c    <= '0;
      cfg_o    <= '0;
      cfg_k3   <= 1'b0;
      cfg_s2   <= 1'b0;
      row      <= '0;
      col      <= '0;
      chn      <= '0;
      och      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      filt_req <= (state_nxt == ST_FILT) && (state != ST_FILT);
      done     <= row_wrap && end_row && end_och;
      if (state == ST_IDLE && q_start) begin
        cfg_w    <= q_width;
        cfg_h    <= q_height;
        cfg_c    <= q_channel;
        cfg_o    <= q_och;
        cfg_k3   <= q_kernel3;
        cfg_s2   <= q_stride2;
        row      <= '0;
        col      <= '0;
        chn      <= '0;
        och      <= '0;
        beat_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + W_FRAME_SIZE'(1);
        if (!end_col) begin
          col <= col + W_SIZE'(1);
        end else begin
          col <= '0;
          if (!end_chn) begin
            chn <= chn + W_CHANNEL'(1);
          end else begin
            chn <= '0;
            if (!end_row) begin
              row <= row + W_SIZE'(1);
            end else begin
              row <= '0;
              // Final tile keeps its beat total visible after o_done.
              if (!end_och) begin
                och      <= och + W_OCH'(1);
                beat_cnt <= '0;
              end
            end
          end
        end
      end
    end
  end

  ifm_row_prefetch #(
    .W_SIZE      (W_SIZE),
    .W_IFM_BUF   (W_IFM_BUF),
    .IFM_BUF_CNT (IFM_BUF_CNT)
  ) u_prefetch (
    .clk      (clk),
    .rstn     (rstn),
    .active   (loader_on),
    .r_in     (r_in),
    .height   (cfg_h),
    .kernel3  (cfg_k3),
    .ifm_done (q_ifm_done),
    .ifm_req  (o_ifm_req),
    .ifm_row  (o_ifm_row),
    .ifm_slot (o_ifm_slot),
    .ready    (ifm_ready)
  );

  assign in_data = state == ST_DATA;

  assign o_filt_req   = filt_req;
  assign o_filt_tile  = och;
  assign o_data_valid = beat;
  assign o_row        = r_in;
  assign o_col        = c_in;
  assign o_chn        = chn;
  assign o_och        = och;
  assign o_beat_cnt   = beat_cnt;
  assign o_done       = done;

  // Flags are qualified by DATA so they read 0 outside a row and hold
  // steady while the PE stalls.
  assign o_first_row = in_data && (r_in == '0);
  assign o_last_row  = in_data && (r_in == cfg_h - W_SIZE'(1));
  assign o_first_col = in_data && (c_in == '0);
  assign o_last_col  = in_data && (c_in == cfg_w - W_SIZE'(1));

endmodule

// File: tb/tb_conv_sched_ctrl.sv
module tb_conv_sched_ctrl;

  typedef struct packed {
    logic [9:0]  row;
    logic [9:0]  col;
    logic [7:0]  chn;
    logic [7:0]  och;
    logic        fr;
    logic        lr;
    logic        fc;
    logic        lc;
    logic [19:0] beat;
  } beat_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        q_start = 1'b0;
  logic [9:0]  q_width = '0, q_height = '0;
  logic [7:0]  q_channel = '0, q_och = '0;
  logic        q_kernel3 = 1'b0, q_stride2 = 1'b0;
  logic        q_filt_done = 1'b0, q_ifm_done = 1'b0, q_pe_ready = 1'b1;
  logic        o_filt_req, o_ifm_req, o_data_valid, o_done;
  logic [7:0]  o_filt_tile, o_chn, o_och;
  logic [9:0]  o_ifm_row, o_row, o_col;
  logic [1:0]  o_ifm_slot;
  logic        o_first_row, o_last_row, o_first_col, o_last_col;
  logic [19:0] o_beat_cnt;
  logic [83:0] all_out;

  int vectors = 0, miscompares = 0;
  beat_t sb[$];

  // tracker state (reset per frame by start_frame)
  int beats_seen, dones_seen, req_cnt, filt_cnt, done_cnt, exp_tile, exp_row;
  bit chk_wait2 = 0, chk_win = 0, hold_chk = 0, frame_run = 0;
  int ifm_lat = 2, filt_lat = 2, pe_mode = 0;

  always #5 clk = ~clk;

  conv_sched_ctrl dut (
    .clk(clk), .rstn(rstn), .q_start(q_start), .q_width(q_width),
    .q_height(q_height), .q_channel(q_channel), .q_och(q_och),
    .q_kernel3(q_kernel3), .q_stride2(q_stride2), .q_filt_done(q_filt_done),
    .q_ifm_done(q_ifm_done), .q_pe_ready(q_pe_ready), .o_filt_req(o_filt_req),
    .o_filt_tile(o_filt_tile), .o_ifm_req(o_ifm_req), .o_ifm_row(o_ifm_row),
    .o_ifm_slot(o_ifm_slot), .o_data_valid(o_data_valid), .o_row(o_row),
    .o_col(o_col), .o_chn(o_chn), .o_och(o_och), .o_first_row(o_first_row),
    .o_last_row(o_last_row), .o_first_col(o_first_col), .o_last_col(o_last_col),
    .o_beat_cnt(o_beat_cnt), .o_done(o_done)
  );

  assign all_out = {o_filt_req, o_filt_tile, o_ifm_req, o_ifm_row, o_ifm_slot,
                    o_data_valid, o_row, o_col, o_chn, o_och, o_first_row,
                    o_last_row, o_first_col, o_last_col, o_beat_cnt, o_done};

  // Buffer manager / PE responder: fixed-latency completions, one in flight.
  initial begin
    int ipend, fpend;
    ipend = 0;
    fpend = 0;
    forever begin
      @(posedge clk);
      #1;
      q_ifm_done  = (ipend == 1);
      q_filt_done = (fpend == 1);
      if (ipend > 0) ipend--;
      if (fpend > 0) fpend--;
      if (o_filt_req) ipend = 0;
      if (o_ifm_req) ipend = ifm_lat;
      if (o_filt_req) fpend = filt_lat;
      if (!rstn) begin
        ipend = 0;
        fpend = 0;
        q_ifm_done = 1'b0;
        q_filt_done = 1'b0;
      end
      case (pe_mode)
        1:       q_pe_ready = ~q_pe_ready;
        2:       q_pe_ready = 1'($urandom_range(0, 1));
        default: q_pe_ready = 1'b1;
      endcase
    end
  end

  // Scoreboard / monitor, sampled on the falling edge.
  initial begin
    beat_t act, exp;
    logic [55:0] snap, prev_snap;
    bit prev_beat, prev_run;
    prev_snap = '0;
    prev_beat = 0;
    prev_run = 0;
    forever begin
      @(negedge clk);
      if (q_ifm_done) dones_seen++;
      if (o_data_valid) begin
        act = {o_row, o_col, o_chn, o_och, o_first_row, o_last_row,
               o_first_col, o_last_col, o_beat_cnt};
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL beat_unexpected got=%h expected none", act);
        end else begin
          exp = sb.pop_front();
          if (act !== exp) begin
            miscompares++;
            $display("FAIL beat got row=%0d col=%0d chn=%0d och=%0d flags=%b%b%b%b cnt=%0d expected row=%0d col=%0d chn=%0d och=%0d flags=%b%b%b%b cnt=%0d",
                     act.row, act.col, act.chn, act.och, act.fr, act.lr, act.fc, act.lc, act.beat,
                     exp.row, exp.col, exp.chn, exp.och, exp.fr, exp.lr, exp.fc, exp.lc, exp.beat);
          end
        end
        if (chk_wait2 && beats_seen == 0) begin
          vectors++;
          if (dones_seen < 2) begin
            miscompares++;
            $display("FAIL first_beat_window rows_loaded=%0d expected >=2", dones_seen);
          end
        end
        beats_seen++;
      end
      if (o_ifm_req) begin
        vectors++;
        if (o_ifm_row !== 10'(exp_row) || o_ifm_slot !== 2'(exp_row % 4)) begin
          miscompares++;
          $display("FAIL ifm_req got row=%0d slot=%0d expected row=%0d slot=%0d",
                   o_ifm_row, o_ifm_slot, exp_row, exp_row % 4);
        end
        if (chk_win && o_ifm_row == 10'd4) begin
          vectors++;
          if (beats_seen < 8) begin
            miscompares++;
            $display("FAIL row4_overwrite beats_before=%0d expected >=8", beats_seen);
          end
        end
        exp_row++;
        req_cnt++;
      end
      if (o_filt_req) begin
        vectors++;
        if (o_filt_tile !== 8'(exp_tile)) begin
          miscompares++;
          $display("FAIL filt_tile got=%0d expected=%0d", o_filt_tile, exp_tile);
        end
        exp_tile++;
        exp_row = 0;
        filt_cnt++;
      end
      if (o_done) done_cnt++;
      snap = {o_row, o_col, o_chn, o_och, o_beat_cnt};
      if (hold_chk && prev_run && frame_run && !prev_beat) begin
        vectors++;
        if (snap !== prev_snap) begin
          miscompares++;
          $display("FAIL hold got=%h expected=%h", snap, prev_snap);
        end
      end
      prev_snap = snap;
      prev_beat = o_data_valid;
      prev_run  = frame_run;
    end
  end

  task automatic push_frame(input int w, h, c, o, s2);
    int s, ho, wo, n;
    beat_t e;
    s  = s2 ? 2 : 1;
    ho = (h + s - 1) / s;
    wo = (w + s - 1) / s;
    for (int t = 0; t < o; t++) begin
      n = 0;
      for (int r = 0; r < ho; r++)
        for (int ch = 0; ch < c; ch++)
          for (int cl = 0; cl < wo; cl++) begin
            e.row  = 10'(r * s);
            e.col  = 10'(cl * s);
            e.chn  = 8'(ch);
            e.och  = 8'(t);
            e.fr   = (r * s == 0);
            e.lr   = (r * s == h - 1);
            e.fc   = (cl * s == 0);
            e.lc   = (cl * s == w - 1);
            e.beat = 20'(n);
            n++;
            sb.push_back(e);
          end
    end
  endtask

  task automatic start_frame(input int w, h, c, o, k3, s2);
    @(posedge clk);
    #1;
    beats_seen = 0; dones_seen = 0; req_cnt = 0; filt_cnt = 0;
    done_cnt = 0; exp_tile = 0; exp_row = 0;
    push_frame(w, h, c, o, s2);
    q_width = 10'(w); q_height = 10'(h); q_channel = 8'(c); q_och = 8'(o);
    q_kernel3 = 1'(k3); q_stride2 = 1'(s2);
    q_start = 1'b1;
    @(posedge clk);
    #1;
    q_start = 1'b0;
    frame_run = 1;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_done && n < 5000);
    if (!o_done) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout got no o_done expected o_done within 5000 cycles");
    end
    repeat (3) @(negedge clk);
    frame_run = 0;
  endtask

  task automatic check_frame(input string name, input int beats, reqs,
                             input int tiles, input int last_cnt);
    vectors++;
    if (beats_seen != beats || sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_beats got=%0d left=%0d expected=%0d left=0", name, beats_seen, sb.size(), beats);
    end
    vectors++;
    if (done_cnt != 1) begin
      miscompares++;
      $display("FAIL %s_done got=%0d expected=1", name, done_cnt);
    end
    vectors++;
    if (filt_cnt != tiles) begin
      miscompares++;
      $display("FAIL %s_filt_reqs got=%0d expected=%0d", name, filt_cnt, tiles);
    end
    if (reqs >= 0) begin
      vectors++;
      if (req_cnt != reqs) begin
        miscompares++;
        $display("FAIL %s_ifm_reqs got=%0d expected=%0d", name, req_cnt, reqs);
      end
    end
    vectors++;
    if (o_beat_cnt !== 20'(last_cnt)) begin
      miscompares++;
      $display("FAIL %s_beat_cnt got=%0d expected=%0d", name, o_beat_cnt, last_cnt);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if (all_out !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h expected=0", all_out);
    end
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (all_out !== '0) begin
      miscompares++;
      $display("FAIL idle_outputs got=%h expected=0", all_out);
    end
  endtask

  task automatic test_1x1();
    start_frame(4, 3, 2, 1, 0, 0);
    wait_done();
    check_frame("k1s1", 24, 3, 1, 24);
  endtask

  task automatic test_3x3_window();
    chk_wait2 = 1;
    chk_win = 1;
    ifm_lat = 3;
    start_frame(4, 5, 1, 1, 1, 0);
    wait_done();
    check_frame("k3s1", 20, 5, 1, 20);
    chk_wait2 = 0;
    chk_win = 0;
    ifm_lat = 2;
  endtask

  task automatic test_stride2();
    start_frame(5, 5, 1, 1, 1, 1);
    wait_done();
    check_frame("k3s2", 9, 5, 1, 9);
  endtask

  task automatic test_och_tiles();
    ifm_lat = 1;
    start_frame(3, 2, 2, 3, 1, 0);
    wait_done();
    check_frame("och3", 36, 6, 3, 12);
    ifm_lat = 2;
  endtask

  task automatic test_backpressure();
    hold_chk = 1;
    pe_mode = 1;
    start_frame(4, 4, 2, 1, 0, 1);
    wait_done();
    check_frame("pe_toggle", 8, -1, 1, 8);
    pe_mode = 2;
    start_frame(5, 4, 3, 2, 1, 0);
    wait_done();
    check_frame("pe_random", 120, 8, 2, 60);
    pe_mode = 0;
    hold_chk = 0;
  endtask

  task automatic test_async_reset();
    int n = 0;
    start_frame(6, 6, 2, 1, 1, 0);
    do begin
      @(negedge clk);
      n++;
    end while (beats_seen < 5 && n < 2000);
    vectors++;
    if (beats_seen < 5) begin
      miscompares++;
      $display("FAIL mid_frame_timeout got=%0d beats expected >=5", beats_seen);
    end
    #2;
    rstn = 1'b0;
    #1;
    vectors++;
    if (all_out !== '0) begin
      miscompares++;
      $display("FAIL async_reset_outputs got=%h expected=0", all_out);
    end
    sb.delete();
    frame_run = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    start_frame(4, 3, 2, 1, 0, 0);
    wait_done();
    check_frame("restart", 24, 3, 1, 24);
  endtask

  initial begin
    test_reset();
    test_1x1();
    test_3x3_window();
    test_stride2();
    test_och_tiles();
    test_backpressure();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
